axi_stream_packet_source: RTL and testbench
===========================================

// Module: axi_stream_packet_source
// PURPOSE
//   AXI-Stream transmitter (master end). Accepts one packet command (byte length, seed,
//   id, dest) and emits it as a beat stream with an incrementing byte pattern, TLAST
//   and partial TKEEP/TSTRB on the final beat. Used as traffic source for stream sinks
//   and as the DUT driving the stream protocol checkers in formal harnesses.
// PARAMETERS
//   BYTE_WIDTH  4   bytes per beat; TDATA is 8*BYTE_WIDTH bits (>=1)
//   ID_WIDTH    1   TID width (>=1)
//   DEST_WIDTH  1   TDEST width (>=1)
//   USER_WIDTH  1   TUSER width (>=1); bit 0 = start-of-packet flag
//   LEN_WIDTH   16  width of packet length in bytes
// PORTS
//   clk            in   1               single clock, all logic on posedge
//   reset          in   1               synchronous, active-high
//   cmd_valid      in   1               packet command valid
//   cmd_ready      out  1               command accepted when cmd_valid && cmd_ready
//   cmd_len        in   LEN_WIDTH       packet length in bytes; 0 = empty packet
//   cmd_seed       in   8               value of byte 0 of the packet
//   cmd_id         in   ID_WIDTH        TID for whole packet
//   cmd_dest       in   DEST_WIDTH      TDEST for whole packet
//   tvalid         out  1               stream beat valid
//   tready         in   1               stream sink ready
//   tdata          out  8*BYTE_WIDTH    beat payload
//   tstrb          out  BYTE_WIDTH      equals tkeep (no position bytes generated)
//   tkeep          out  BYTE_WIDTH      valid-byte mask
//   tlast          out  1               final beat of packet
//   tid            out  ID_WIDTH        latched cmd_id
//   tdest          out  DEST_WIDTH      latched cmd_dest
//   tuser          out  USER_WIDTH      bit0 = first beat; other bits 0
//   busy           out  1               state != IDLE
//   pkt_count      out  16              completed packets (last-beat handshakes), wraps
// BEHAVIOUR
//   - Reset: state IDLE, tvalid=0, cmd_ready=0 during reset cycle then 1, tdata/tkeep/
//     tstrb/tlast/tid/tdest/tuser=0, pkt_count=0, busy=0. Reset mid-packet abandons it;
//     tvalid is 0 on the cycle after the reset edge; no partial resumption.
//   - FSM: IDLE -> SEND on cmd handshake with cmd_len!=0; cmd_len==0 is accepted and
//     dropped (stays IDLE, pkt_count unchanged). SEND -> IDLE on tvalid&&tready&&tlast.
//   - cmd_ready = (state==IDLE) && !reset. Command latched on handshake.
//   - Latency: cmd handshake at edge N -> first beat tvalid=1 after edge N, no bubble.
//     After last beat handshake, cmd_ready=1 next cycle (one idle cycle between packets).
//   - Beats: nbeats = ceil(cmd_len/BYTE_WIDTH). Beat b lane i carries byte k=b*BYTE_WIDTH+i
//     = (cmd_seed+k) mod 256. tlast=1 only on beat nbeats-1.
//   - tkeep=all ones except last beat: low (cmd_len mod BYTE_WIDTH) bits set, all ones if
//     remainder 0. Lanes with tkeep=0 drive tdata byte 0. tstrb==tkeep always.
//   - Handshake: once tvalid=1 it stays 1 until tready; all payload/side-band outputs are
//     registered and held stable while tvalid && !tready. Next beat presented on the cycle
//     after each handshake; sustained tready=1 gives one beat per cycle.
//   - tvalid never depends combinationally on tready.
//   - Counters: byte offset counter LEN_WIDTH+1 bits (no overflow at max cmd_len);
//     seed arithmetic mod 256; pkt_count wraps 0xFFFF->0.
// STRUCTURE
//   - Shared axi_stream_pkg: FSM state encoding (IDLE, SEND), function
//     last_keep(len_mod, BYTE_WIDTH) returning the final-beat keep mask.
//   - No sub-module required; optional axi_stream_pattern_gen (seed,offset -> tdata lanes)
//     if pattern logic is reused by a checker-side generator.
// TESTING
//   - Reset then cmd len=8 seed=0x10, tready=1, BYTE_WIDTH=4 -> 2 beats tdata 0x13121110,
//     0x17161514; tkeep=0xF both; tlast on beat 2; tuser[0] on beat 1; pkt_count=1.
//   - len=6 seed=0xFE -> beat1 0x0100FFFE keep 0xF; beat2 0x00000302 keep 0x3, tlast=1.
//   - len=5 with tready low for 3 cycles mid-packet -> tvalid stays 1, all outputs stable
//     while stalled, stream completes unchanged afterwards.
//   - len=0 command -> accepted, tvalid never asserted, pkt_count unchanged, cmd_ready=1.
//   - reset asserted during beat 2 of len=16 -> tvalid=0 next cycle, pkt_count=0,
//     new cmd len=4 afterwards produces single beat with tuser[0]=1, tlast=1.
//   - Formal: bind stream protocol checker to outputs; prove stability, no tvalid in reset.

Source files
------------

// File: rtl/axi_stream_pkg.sv
// -----------------------------------------------------------------------------
// axi_stream_pkg
//   Shared definitions for the AXI-Stream packet source and any checker-side
//   pattern generator:
//     state_e    - packet source FSM encoding (IDLE, SEND)
//     last_keep  - final-beat TKEEP mask for a given (length mod byte width)
// -----------------------------------------------------------------------------
package axi_stream_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // Upper bound on bytes per beat supported by last_keep.
   localparam int MAX_BYTE_WIDTH = 64;

   // Keep mask for the final beat: the low len_mod lanes are set, or every
   // lane of the beat when the packet fills the final beat exactly (len_mod 0).
   function automatic logic [MAX_BYTE_WIDTH-1:0] last_keep(input int len_mod,
                                                          input int byte_width);
      logic [MAX_BYTE_WIDTH-1:0] mask;
      mask = '0;
      for (int i = 0; i < MAX_BYTE_WIDTH; i++) begin
         if ((i < byte_width) && ((len_mod == 0) || (i < len_mod))) begin
            mask[i] = 1'b1;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/axi_stream_pattern_gen.sv
// -----------------------------------------------------------------------------
// axi_stream_pattern_gen
//   Combinational beat builder for the incrementing byte pattern. Given the
//   packet seed, the byte offset of the beat and the bytes still to send from
//   that offset, produces the beat payload, keep mask and last flag.
//   Lane i carries (seed + offset + i) mod 256; lanes beyond the packet end
//   are zero with keep cleared.
// Ports
//   seed_i       8             byte 0 value of the packet
//   offset_i     LEN_WIDTH+1   byte offset of this beat within the packet
//   remaining_i  LEN_WIDTH+1   bytes left from offset_i (>= 1 when used)
//   tdata_o      8*BYTE_WIDTH  beat payload
//   tkeep_o      BYTE_WIDTH    valid-byte mask
//   tlast_o      1             this beat ends the packet
// -----------------------------------------------------------------------------
module axi_stream_pattern_gen
   import axi_stream_pkg::*;
#(
   parameter int BYTE_WIDTH = 4,
   parameter int LEN_WIDTH  = 16
) (
   input  logic [7:0]              seed_i,
   input  logic [LEN_WIDTH:0]      offset_i,
   input  logic [LEN_WIDTH:0]      remaining_i,
   output logic [8*BYTE_WIDTH-1:0] tdata_o,
   output logic [BYTE_WIDTH-1:0]   tkeep_o,
   output logic                    tlast_o
);

   localparam logic [LEN_WIDTH:0] BW_L = (LEN_WIDTH + 1)'(BYTE_WIDTH);

   logic [MAX_BYTE_WIDTH-1:0] keep_full;
   logic [7:0]                base;

   // NOTE: every signal written in always_comb is given a value on every path
   // (defaults first), otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      keep_full = '1;
      tdata_o   = '0;
      base      = seed_i + offset_i[7:0];
      tlast_o   = (remaining_i <= BW_L);

      if (tlast_o) begin
         // A full final beat is remainder 0, which last_keep maps to all ones.
         keep_full = last_keep((remaining_i == BW_L) ? 0 : int'(remaining_i),
                               BYTE_WIDTH);
      end
      tkeep_o = keep_full[BYTE_WIDTH-1:0];

      for (int i = 0; i < BYTE_WIDTH; i++) begin
         tdata_o[8*i +: 8] = tkeep_o[i] ? (base + 8'(i)) : 8'h00;
      end
   end

endmodule

// File: rtl/axi_stream_packet_source.sv
// -----------------------------------------------------------------------------
// axi_stream_packet_source
//   AXI-Stream master that turns one packet command into a beat stream with an
//   incrementing byte pattern, TLAST on the final beat and a partial TKEEP/TSTRB
//   when the length is not a multiple of the beat width. All stream outputs are
//   registered; tvalid never depends on tready combinationally.
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle, not in reset)
//   cmd_len               packet length in bytes, 0 = dropped empty packet
//   cmd_seed              value of byte 0
//   cmd_id, cmd_dest      TID / TDEST for the whole packet
//   tvalid/tready         stream handshake
//   tdata, tkeep, tstrb   payload and byte masks (tstrb == tkeep)
//   tlast                 final beat of packet
//   tid, tdest            latched command side-band
//   tuser                 bit 0 flags the first beat, other bits zero
//   busy                  a packet is in flight
//   pkt_count             completed packets, wraps at 16 bits
// -----------------------------------------------------------------------------
module axi_stream_packet_source
   import axi_stream_pkg::*;
#(
   parameter int BYTE_WIDTH = 4,
   parameter int ID_WIDTH   = 1,
   parameter int DEST_WIDTH = 1,
   parameter int USER_WIDTH = 1,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [LEN_WIDTH-1:0]    cmd_len,
   input  logic [7:0]              cmd_seed,
   input  logic [ID_WIDTH-1:0]     cmd_id,
   input  logic [DEST_WIDTH-1:0]   cmd_dest,
   output logic                    tvalid,
   input  logic                    tready,
   output logic [8*BYTE_WIDTH-1:0] tdata,
   output logic [BYTE_WIDTH-1:0]   tstrb,
   output logic [BYTE_WIDTH-1:0]   tkeep,
   output logic                    tlast,
   output logic [ID_WIDTH-1:0]     tid,
   output logic [DEST_WIDTH-1:0]   tdest,
   output logic [USER_WIDTH-1:0]   tuser,
   output logic                    busy,
   output logic [15:0]             pkt_count
);

   localparam logic [LEN_WIDTH:0] BW_L = (LEN_WIDTH + 1)'(BYTE_WIDTH);

   state_e                  state_q;
   logic                    tvalid_q;
   logic [8*BYTE_WIDTH-1:0] tdata_q;
   logic [BYTE_WIDTH-1:0]   tkeep_q;
   logic                    tlast_q;
   logic [ID_WIDTH-1:0]     tid_q;
   logic [DEST_WIDTH-1:0]   tdest_q;
   logic [USER_WIDTH-1:0]   tuser_q;
   logic [15:0]             pkt_count_q;
   logic [7:0]              seed_q;
   // One bit wider than cmd_len so the offset past the last beat never wraps.
   logic [LEN_WIDTH:0]      len_q;
   logic [LEN_WIDTH:0]      offset_q;

   // Next beat to present: the first beat of an incoming command while idle,
   // otherwise the beat following the one currently on the bus.
   logic [7:0]              gen_seed;
   logic [LEN_WIDTH:0]      gen_offset;
   logic [LEN_WIDTH:0]      gen_remaining;
   logic [8*BYTE_WIDTH-1:0] beat_data_d;
   logic [BYTE_WIDTH-1:0]   beat_keep_d;
   logic                    beat_last_d;

   always_comb begin
      if (state_q == ST_IDLE) begin
         gen_seed      = cmd_seed;
         gen_offset    = '0;
         gen_remaining = {1'b0, cmd_len};
      end else begin
         gen_seed      = seed_q;
         gen_offset    = offset_q;
         gen_remaining = len_q - offset_q;
      end
   end

   axi_stream_pattern_gen #(
      .BYTE_WIDTH (BYTE_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH)
   ) u_pattern_gen (
      .seed_i      (gen_seed),
      .offset_i    (gen_offset),
      .remaining_i (gen_remaining),
      .tdata_o     (beat_data_d),
      .tkeep_o     (beat_keep_d),
      .tlast_o     (beat_last_d)
   );

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples the pre-edge values and ordering inside the block is moot.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tvalid_q    <= 1'b0;
         tdata_q     <= '0;
         tkeep_q     <= '0;
         tlast_q     <= 1'b0;
         tid_q       <= '0;
         tdest_q     <= '0;
         tuser_q     <= '0;
         pkt_count_q <= '0;
         seed_q      <= '0;
         len_q       <= '0;
         offset_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // cmd_ready is high whenever idle out of reset; a zero-length
               // command completes the handshake and is simply discarded.
               if (cmd_valid && (cmd_len != '0)) begin
                  state_q  <= ST_SEND;
                  seed_q   <= cmd_seed;
                  len_q    <= {1'b0, cmd_len};
                  offset_q <= BW_L;
                  tid_q    <= cmd_id;
                  tdest_q  <= cmd_dest;
                  tvalid_q <= 1'b1;
                  tdata_q  <= beat_data_d;
                  tkeep_q  <= beat_keep_d;
                  tlast_q  <= beat_last_d;
                  tuser_q  <= USER_WIDTH'(1);
               end
            end

            ST_SEND: begin
               // tvalid is always high here; with tready low nothing changes.
               if (tready) begin
                  if (tlast_q) begin
                     state_q     <= ST_IDLE;
                     tvalid_q    <= 1'b0;
                     tdata_q     <= '0;
                     tkeep_q     <= '0;
                     tlast_q     <= 1'b0;
                     tid_q       <= '0;
                     tdest_q     <= '0;
                     tuser_q     <= '0;
                     pkt_count_q <= pkt_count_q + 16'd1;
                  end else begin
                     tdata_q  <= beat_data_d;
                     tkeep_q  <= beat_keep_d;
                     tlast_q  <= beat_last_d;
                     tuser_q  <= '0;
                     offset_q <= offset_q + BW_L;
                  end
               end
            end

            default: begin
               state_q  <= ST_IDLE;
               tvalid_q <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready = (state_q == ST_IDLE) && !reset;
   assign busy      = (state_q != ST_IDLE);
   assign tvalid    = tvalid_q;
   assign tdata     = tdata_q;
   assign tkeep     = tkeep_q;
   assign tstrb     = tkeep_q;
   assign tlast     = tlast_q;
   assign tid       = tid_q;
   assign tdest     = tdest_q;
   assign tuser     = tuser_q;
   assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axi_stream_packet_source.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_packet_source
//   Directed bench for axi_stream_packet_source with BYTE_WIDTH = 4. Inputs are
//   driven 1 ns after the rising edge and outputs are checked there as well.
// -----------------------------------------------------------------------------
module tb_axi_stream_packet_source;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_len;
   logic [7:0]  cmd_seed;
   logic [0:0]  cmd_id;
   logic [0:0]  cmd_dest;
   logic        tvalid;
   logic        tready;
   logic [31:0] tdata;
   logic [3:0]  tstrb;
   logic [3:0]  tkeep;
   logic        tlast;
   logic [0:0]  tid;
   logic [0:0]  tdest;
   logic [0:0]  tuser;
   logic        busy;
   logic [15:0] pkt_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_stream_packet_source #(
      .BYTE_WIDTH (4),
      .ID_WIDTH   (1),
      .DEST_WIDTH (1),
      .USER_WIDTH (1),
      .LEN_WIDTH  (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_len   (cmd_len),
      .cmd_seed  (cmd_seed),
      .cmd_id    (cmd_id),
      .cmd_dest  (cmd_dest),
      .tvalid    (tvalid),
      .tready    (tready),
      .tdata     (tdata),
      .tstrb     (tstrb),
      .tkeep     (tkeep),
      .tlast     (tlast),
      .tid       (tid),
      .tdest     (tdest),
      .tuser     (tuser),
      .busy      (busy),
      .pkt_count (pkt_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one command for a single edge.
   task automatic send_cmd(input logic [15:0] len, input logic [7:0] seed,
                           input logic id, input logic dest);
      cmd_valid = 1'b1;
      cmd_len   = len;
      cmd_seed  = seed;
      cmd_id    = id;
      cmd_dest  = dest;
      tick();
      cmd_valid = 1'b0;
      cmd_len   = '0;
      cmd_seed  = '0;
      cmd_id    = '0;
      cmd_dest  = '0;
   endtask

   // Compare the beat currently on the bus against hand-computed values.
   task automatic check_beat(input string tag, input logic [31:0] data,
                             input logic [3:0] keep, input logic last,
                             input logic first, input logic id, input logic dest);
      check({tag, ".tvalid"}, tvalid, 1'b1);
      check({tag, ".tdata"},  tdata,  data);
      check({tag, ".tkeep"},  tkeep,  keep);
      check({tag, ".tstrb"},  tstrb,  keep);
      check({tag, ".tlast"},  tlast,  last);
      check({tag, ".tuser"},  tuser,  first);
      check({tag, ".tid"},    tid,    id);
      check({tag, ".tdest"},  tdest,  dest);
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_len   = '0;
      cmd_seed  = '0;
      cmd_id    = '0;
      cmd_dest  = '0;
      tready    = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst.tvalid",    tvalid,    1'b0);
      check("rst.cmd_ready", cmd_ready, 1'b0);
      check("rst.busy",      busy,      1'b0);
      check("rst.pkt_count", pkt_count, 16'd0);
      check("rst.tdata",     tdata,     32'h0);
      check("rst.tkeep",     tkeep,     4'h0);
      check("rst.tlast",     tlast,     1'b0);
      check("rst.tuser",     tuser,     1'b0);
      reset = 1'b0;
      #1;
      check("idle.cmd_ready", cmd_ready, 1'b1);

      // len=8 seed=0x10: two full beats
      tready = 1'b1;
      send_cmd(16'd8, 8'h10, 1'b1, 1'b1);
      check("p1.busy",      busy,      1'b1);
      check("p1.cmd_ready", cmd_ready, 1'b0);
      check_beat("p1.b0", 32'h13121110, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      check_beat("p1.b1", 32'h17161514, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      check("p1.done.tvalid",    tvalid,    1'b0);
      check("p1.done.pkt_count", pkt_count, 16'd1);
      check("p1.done.cmd_ready", cmd_ready, 1'b1);
      check("p1.done.busy",      busy,      1'b0);

      // len=6 seed=0xFE: byte wrap and partial final beat
      send_cmd(16'd6, 8'hFE, 1'b0, 1'b0);
      check_beat("p2.b0", 32'h0100FFFE, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check_beat("p2.b1", 32'h00000302, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("p2.done.tvalid",    tvalid,    1'b0);
      check("p2.done.pkt_count", pkt_count, 16'd2);

      // len=5 seed=0x20 with a 3-cycle stall on the final beat
      send_cmd(16'd5, 8'h20, 1'b1, 1'b0);
      check_beat("p3.b0", 32'h23222120, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_beat($sformatf("p3.stall%0d", i), 32'h00000024, 4'h1, 1'b1, 1'b0,
                    1'b1, 1'b0);
         tick();
      end
      check_beat("p3.b1", 32'h00000024, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0);
      check("p3.stall.pkt_count", pkt_count, 16'd2);
      tready = 1'b1;
      tick();
      check("p3.done.tvalid",    tvalid,    1'b0);
      check("p3.done.pkt_count", pkt_count, 16'd3);

      // len=0: accepted and dropped
      check("p4.cmd_ready", cmd_ready, 1'b1);
      send_cmd(16'd0, 8'h55, 1'b1, 1'b1);
      check("p4.tvalid",    tvalid,    1'b0);
      check("p4.busy",      busy,      1'b0);
      check("p4.cmd_ready", cmd_ready, 1'b1);
      tick();
      check("p4.tvalid2",   tvalid,    1'b0);
      check("p4.pkt_count", pkt_count, 16'd3);

      // len=16 seed=0x00, reset during beat 2
      send_cmd(16'd16, 8'h00, 1'b0, 1'b1);
      check_beat("p5.b0", 32'h03020100, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      check_beat("p5.b1", 32'h07060504, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      tick();
      check("p5.rst.tvalid",    tvalid,    1'b0);
      check("p5.rst.pkt_count", pkt_count, 16'd0);
      check("p5.rst.busy",      busy,      1'b0);
      check("p5.rst.tdata",     tdata,     32'h0);
      reset = 1'b0;
      #1;
      check("p5.rst.cmd_ready", cmd_ready, 1'b1);

      // len=4 seed=0x40 after reset: single full beat
      send_cmd(16'd4, 8'h40, 1'b1, 1'b0);
      check_beat("p6.b0", 32'h43424140, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      check("p6.done.tvalid",    tvalid,    1'b0);
      check("p6.done.pkt_count", pkt_count, 16'd1);

      // len=3 seed=0xFD, back-to-back after one idle cycle: single partial beat
      send_cmd(16'd3, 8'hFD, 1'b0, 1'b0);
      check_beat("p7.b0", 32'h00FFFEFD, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      check("p7.done.pkt_count", pkt_count, 16'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
